// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: host-side control and display-side outputs of the 7-segment scan driver
interface seg_scan_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int VAL_W  = 7
);
  logic                      en;
  logic [NUM_CH*VAL_W-1:0]   ch_time;
  logic [NUM_CH-1:0]         blink_mask;
  logic [NUM_CH-1:0]         dp_mask;
  logic                      lz_blank;
  logic [2*NUM_CH-1:0]       sel;
  logic [7:0]                seg_led;
  logic                      frame_sync;
  modport master (
    output en, ch_time, blink_mask, dp_mask, lz_blank,
    input  sel, seg_led, frame_sync
  );
  modport slave (
    input  en, ch_time, blink_mask, dp_mask, lz_blank,
    output sel, seg_led, frame_sync
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan driver for NUM_CH two-digit countdown channels
module seg_scan_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int VAL_W       = 7,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 250,
  parameter bit SEG_ACT_LOW = 1,
  parameter bit SEL_ACT_LOW = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int ND    = 2 * NUM_CH;
  localparam int DIV_W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = $clog2(ND);
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BLK_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0]    SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [ND-1:0] SEL_OFF = SEL_ACT_LOW ? {ND{1'b1}} : {ND{1'b0}};

  typedef enum logic [2:0] {IDLE, LATCH, DIV, NEXT, DONE} conv_st_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [DIG_W-1:0] dig_idx, nxt_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_ph, nxt_ph, tick, blk_wrap, fs;

  conv_st_t st, nxt_st;
  logic [NUM_CH-1:0][VAL_W-1:0] snap;
  logic [CH_W-1:0]  ch, ch_nxt, ld_ch;
  logic [VAL_W-1:0] rem, ld_val;
  logic             ld_ovf, last, rem_lt;
  logic [NUM_CH-1:0][3:0] wrk_tens, wrk_units, sh_tens, sh_units;
  logic [NUM_CH-1:0]      wrk_ovf, sh_ovf;

  logic [CH_W-1:0] d_ch;
  logic            d_u, d_ovf, d_blank;
  logic [3:0]      d_val;
  logic [7:0]      seg_hi, seg_nxt;
  logic [ND-1:0]   sel_hi, sel_nxt;

  assign tick     = div_cnt == DIV_W'(SCAN_DIV - 1);
  assign nxt_idx  = dig_idx == DIG_W'(ND - 1) ? '0 : dig_idx + 1'b1;
  assign blk_wrap = tick && blink_cnt == BLK_W'(BLINK_DIV - 1);
  assign nxt_ph   = blink_ph ^ blk_wrap;
  assign bus.frame_sync = fs;

  // Slot divider, digit index, blink phase and frame pulse; free-running regardless of en
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      dig_idx   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      fs        <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      fs      <= tick && nxt_idx == '0;
      if (tick) begin
        dig_idx   <= nxt_idx;
        blink_cnt <= blk_wrap ? '0 : blink_cnt + 1'b1;
        blink_ph  <= nxt_ph;
      end
    end
  end

  // Converter state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) st <= IDLE;
    else st <= nxt_st;
  end

  // Converter next state; LATCH loads channel 0 straight from the input, NEXT loads the following channel from the snapshot
  always_comb begin
    ch_nxt = ch + 1'b1;
    ld_ch  = st == LATCH ? '0 : ch_nxt;
    ld_val = st == LATCH ? bus.ch_time[VAL_W-1:0] : snap[ch_nxt];
    ld_ovf = 32'(ld_val) > 32'd99;
    last   = ch == CH_W'(NUM_CH - 1);
    rem_lt = rem < VAL_W'(10);
    nxt_st = st == IDLE  ? (fs ? LATCH : IDLE) :
             st == LATCH ? (ld_ovf ? NEXT : DIV) :
             st == DIV   ? (rem_lt ? NEXT : DIV) :
             st == NEXT  ? (last ? DONE : (ld_ovf ? NEXT : DIV)) : IDLE;
  end

  // Converter datapath: subtract-10 per cycle, then publish every channel to the shadow at once
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap      <= '0;
      ch        <= '0;
      rem       <= '0;
      wrk_tens  <= '0;
      wrk_units <= '0;
      wrk_ovf   <= '0;
      sh_tens   <= '0;
      sh_units  <= '0;
      sh_ovf    <= '0;
    end else begin
      if (st == LATCH) snap <= bus.ch_time;
      if (st == LATCH || (st == NEXT && !last)) begin
        ch               <= ld_ch;
        rem              <= ld_val;
        wrk_tens[ld_ch]  <= 4'd0;
        wrk_units[ld_ch] <= 4'd0;
        wrk_ovf[ld_ch]   <= ld_ovf;
      end
      if (st == DIV && !rem_lt) begin
        rem          <= rem - VAL_W'(10);
        wrk_tens[ch] <= wrk_tens[ch] + 4'd1;
      end
      if (st == DIV && rem_lt) wrk_units[ch] <= rem[3:0];
      if (st == DONE) begin
        sh_tens  <= wrk_tens;
        sh_units <= wrk_units;
        sh_ovf   <= wrk_ovf;
      end
    end
  end

  // Digit about to be shown in the next slot, using the blink phase that slot will see
  always_comb begin
    d_ch    = CH_W'(nxt_idx >> 1);
    d_u     = nxt_idx[0];
    d_val   = d_u ? sh_units[d_ch] : sh_tens[d_ch];
    d_ovf   = sh_ovf[d_ch];
    d_blank = (nxt_ph && bus.blink_mask[d_ch]) ||
              (!d_u && !d_ovf && bus.lz_blank && sh_tens[d_ch] == 4'd0);
    seg_hi  = {d_u && bus.dp_mask[d_ch], d_ovf ? 7'h40 : seg7(d_val)};
    seg_nxt = d_blank ? SEG_OFF : (SEG_ACT_LOW ? ~seg_hi : seg_hi);
    sel_hi  = ND'(1) << nxt_idx;
    sel_nxt = d_blank ? SEL_OFF : (SEL_ACT_LOW ? ~sel_hi : sel_hi);
  end

  // sel and seg_led registered together; disable blanks at once, enable waits for a slot boundary
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.sel     <= SEL_OFF;
      bus.seg_led <= SEG_OFF;
    end else if (!bus.en) begin
      bus.sel     <= SEL_OFF;
      bus.seg_led <= SEG_OFF;
    end else if (tick) begin
      bus.sel     <= sel_nxt;
      bus.seg_led <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl against a per-slot display model
module tb_seg_scan_ctrl;
  localparam int NC = 2, VW = 7, SD = 40, BD = 4, ND = 4;
  localparam int RST_SLOT = 152;
  localparam int N_CYC = 330 * SD;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } exp_t;

  localparam exp_t OFF = {4'hF, 8'hFF};
  localparam logic [6:0] LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  seg_scan_ctrl_if #(.NUM_CH(NC), .VAL_W(VW)) bus ();

  seg_scan_ctrl #(
    .NUM_CH(NC), .VAL_W(VW), .SCAN_DIV(SD), .BLINK_DIV(BD),
    .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus.slave)
  );

  int   n_cmp = 0, n_bad = 0, cyc = 0, mj;
  int   shadow [NC];
  int   pending [NC];
  exp_t q [$];
  exp_t slot_val, got;

  // Clocks since reset release; after edge j the bench reads cyc == j
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int k);
    int idx, c, u, ph, v, tens, units;
    logic ovf;
    logic [6:0] pat;
    logic [3:0] s;
    exp_t e;
    if (k == 0 || !bus.en) return OFF;
    idx   = k % ND;
    c     = idx / 2;
    u     = idx % 2;
    ph    = (k / BD) % 2;
    v     = shadow[c];
    ovf   = v > 99;
    tens  = v / 10;
    units = v % 10;
    if ((ph == 1 && bus.blink_mask[c]) || (u == 0 && !ovf && bus.lz_blank && tens == 0))
      return OFF;
    pat = ovf ? 7'h40 : LUT[u == 1 ? units : tens];
    s = 4'b0001 << idx;
    e.sel = ~s;
    e.seg = ~{(u == 1) && bus.dp_mask[c], pat};
    return e;
  endfunction

  task automatic set_ch(input int c1, input int c0);
    bus.ch_time = {7'(c1), 7'(c0)};
  endtask

  function automatic int rand_val();
    int r;
    r = $urandom_range(0, 9);
    return r < 2 ? $urandom_range(100, 127) : r < 4 ? $urandom_range(0, 9) : $urandom_range(0, 99);
  endfunction

  task automatic boundary(input int k);
    if (k > 0 && k % ND == 0)
      for (int c = 0; c < NC; c++) pending[c] = int'(bus.ch_time[c*VW +: VW]);
    if (k > ND && k % ND == 1) shadow = pending;
    slot_val = model(k);
    q.push_back(slot_val);
  endtask

  task automatic change(input int k);
    case (k)
      13: bus.lz_blank = 1'b1;
      21: set_ch(25, 0);
      29: begin bus.lz_blank = 1'b0; set_ch(120, 25); end
      37: bus.dp_mask = 2'b10;
      45: begin bus.dp_mask = 2'b00; bus.blink_mask = 2'b01; end
      55: begin bus.blink_mask = 2'b00; set_ch(120, 24); end
      default:
        if (k >= 60) begin
          if ($urandom_range(0, 2) == 0) set_ch(rand_val(), rand_val());
          if ($urandom_range(0, 3) == 0) bus.blink_mask = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) bus.dp_mask = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) bus.lz_blank = 1'($urandom_range(0, 1));
          bus.en = $urandom_range(0, 7) != 0;
        end
    endcase
    q.push_back(bus.en ? slot_val : OFF);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sel"}, 32'(bus.sel), 32'hF);
    check({tag, "_seg"}, 32'(bus.seg_led), 32'hFF);
    check({tag, "_fsync"}, 32'(bus.frame_sync), 32'h0);
  endtask

  task automatic clear_model();
    q.delete();
    for (int c = 0; c < NC; c++) begin
      shadow[c] = 0;
      pending[c] = 0;
    end
  endtask

  // Monitor: frame pulse every cycle, and one scoreboard entry mid-slot and just after each input update
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      mj = cyc;
      check("frame_sync", 32'(bus.frame_sync),
            32'(mj > 0 && mj % SD == 0 && (mj / SD) % ND == 0));
      if (mj % SD == SD / 2 || mj % SD == 3 * SD / 4 + 1) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", 32'(q.size()), 32'h1);
        end else begin
          got = q.pop_front();
          check("sel", 32'(bus.sel), 32'(got.sel));
          check("seg_led", 32'(bus.seg_led), 32'(got.seg));
        end
      end
    end
  end

  initial begin
    int j;
    bit rst_done;
    rst_done = 1'b0;
    bus.en = 1'b1;
    bus.lz_blank = 1'b0;
    bus.blink_mask = '0;
    bus.dp_mask = '0;
    set_ch(25, 9);
    clear_model();
    repeat (3) @(negedge sys_clk);
    reset_checks("por");
    sys_rst_n = 1'b1;
    boundary(0);
    for (int n = 0; n < N_CYC; n++) begin
      @(negedge sys_clk);
      j = cyc;
      if (j % SD == 0) boundary(j / SD);
      else if (j % SD == 3 * SD / 4) change(j / SD);
      else if (!rst_done && j / SD == RST_SLOT && j % SD == 5) begin
        rst_done = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        reset_checks("mid_rst");
        clear_model();
        repeat (3) @(negedge sys_clk);
        reset_checks("held_rst");
        sys_rst_n = 1'b1;
        boundary(0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
